// File: rtl/lcd_tou_cmd_seq_pkg.sv
// Shared types and constants for the LCD/touch command sequencer.
// Holds the command opcodes, FSM encoding, AXI response codes and register offsets.
package lcd_tou_cmd_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_DELAY = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_GAP,
        ST_DLY,
        ST_RSP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] REG0 = 32'h0;
    localparam logic [31:0] REG1 = 32'h4;
    localparam logic [31:0] REG2 = 32'h8;
    localparam logic [31:0] REG3 = 32'hC;

endpackage

// File: rtl/lcd_tou_cmd_sequencer_xact.sv
// Single-beat AXI4-Lite write/read engine; valids assert the cycle after start, done pulses on B/R handshake.
// AW and W drop independently on their own handshakes; the caller must not start while a beat is in flight.
module lcd_tou_axil_xact #(
    parameter int ADDR_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic              is_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [1:0]        resp,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);
    import lcd_tou_cmd_seq_pkg::*;

    state_e            state_q, state_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d = addr;
                    if (is_write) begin
                        wdata_d   = wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_AR;
                    end
                end
            end
            ST_WR: begin
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                // Leave once each channel has either already finished or finishes now.
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready))
                    state_d = ST_WR_B;
            end
            ST_WR_B:  if (m_axi_bvalid) state_d = ST_IDLE;
            ST_RD_AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_R;
                end
            end
            ST_RD_R:  if (m_axi_rvalid) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == ST_WR_B);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == ST_RD_R);

    assign done  = ((state_q == ST_WR_B) && m_axi_bvalid) || ((state_q == ST_RD_R) && m_axi_rvalid);
    assign rdata = m_axi_rdata;
    assign resp  = (state_q == ST_WR_B) ? m_axi_bresp : m_axi_rresp;

endmodule

// File: rtl/lcd_tou_cmd_sequencer.sv
// Command sequencer (WRITE/READ/POLL/DELAY) driving AXI4-Lite; WRITE/READ respond at accept+3 with a zero-wait slave.
// One command at a time, rsp_valid is a one-cycle pulse with no backpressure; LCD_TOU_CMD_SEQ_TIMEOUT_EN bounds POLL reads.
module lcd_tou_cmd_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int POLL_GAP = 16,
    parameter int POLL_MAX = 1024,
    parameter int DLY_W    = 24
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    input  logic [31:0]       cmd_mask,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_resp,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);
    import lcd_tou_cmd_seq_pkg::*;

    localparam logic [DLY_W-1:0] GAP_LOAD = DLY_W'(POLL_GAP);

    state_e            state_q, state_d;
    cmd_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       mask_q, mask_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_err_q, rsp_err_d;

    logic              xact_start, xact_is_write, xact_done;
    logic [ADDR_W-1:0] xact_addr;
    logic [31:0]       xact_rdata;
    logic [1:0]        xact_resp;
    logic              poll_hit, poll_exhausted;

`ifdef LCD_TOU_CMD_SEQ_TIMEOUT_EN
    localparam int PW = $clog2(POLL_MAX + 1);
    logic [PW-1:0] attempts_q, attempts_d;
    assign poll_exhausted = (PW'(attempts_q + 1'b1) == PW'(POLL_MAX));
`else
    logic unused_poll_max;
    assign unused_poll_max = (POLL_MAX != 0);
    assign poll_exhausted  = 1'b0;
`endif

    assign cmd_ready = (state_q == ST_IDLE) && !ARESET;
    assign poll_hit  = ((xact_rdata & mask_q) == (data_q & mask_q));

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_err_d     = rsp_err_q;
        xact_start    = 1'b0;
        xact_is_write = (op_q == OP_WRITE);
        xact_addr     = addr_q;
`ifdef LCD_TOU_CMD_SEQ_TIMEOUT_EN
        attempts_d    = attempts_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // The first beat launches straight from the command port so AXI valids rise at accept+1.
                xact_is_write = (cmd_op == OP_WRITE);
                xact_addr     = cmd_addr;
                if (cmd_valid && cmd_ready) begin
                    op_d   = cmd_op_e'(cmd_op);
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    mask_d = cmd_mask;
`ifdef LCD_TOU_CMD_SEQ_TIMEOUT_EN
                    attempts_d = '0;
`endif
                    case (cmd_op_e'(cmd_op))
                        OP_WRITE: begin
                            xact_start = 1'b1;
                            state_d    = ST_WR;
                        end
                        OP_DELAY: begin
                            cnt_d = cmd_data[DLY_W-1:0];
                            if (cmd_data[DLY_W-1:0] == '0) begin
                                rsp_data_d = '0;
                                rsp_resp_d = RESP_OKAY;
                                rsp_err_d  = 1'b0;
                                state_d    = ST_RSP;
                            end else begin
                                state_d = ST_DLY;
                            end
                        end
                        default: begin
                            xact_start = 1'b1;
                            state_d    = ST_RD_AR;
                        end
                    endcase
                end
            end
            ST_WR, ST_RD_AR: begin
                if (xact_done) begin
                    if (op_q == OP_POLL && xact_resp == RESP_OKAY && !poll_hit && !poll_exhausted) begin
`ifdef LCD_TOU_CMD_SEQ_TIMEOUT_EN
                        attempts_d = attempts_q + 1'b1;
`endif
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        rsp_data_d = (op_q == OP_WRITE) ? 32'h0 : xact_rdata;
                        rsp_resp_d = xact_resp;
                        rsp_err_d  = (xact_resp != RESP_OKAY) || (op_q == OP_POLL && !poll_hit);
                        state_d    = ST_RSP;
                    end
                end
            end
            ST_GAP: begin
                // POLL_GAP of 0 or 1 both yield a single idle cycle between reads.
                if (cnt_q <= DLY_W'(1)) begin
                    xact_start = 1'b1;
                    state_d    = ST_RD_AR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DLY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= DLY_W'(1)) begin
                    rsp_data_d = '0;
                    rsp_resp_d = RESP_OKAY;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RSP;
                end
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WRITE;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_resp_q <= RESP_OKAY;
            rsp_err_q  <= 1'b0;
`ifdef LCD_TOU_CMD_SEQ_TIMEOUT_EN
            attempts_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_resp_q <= rsp_resp_d;
            rsp_err_q  <= rsp_err_d;
`ifdef LCD_TOU_CMD_SEQ_TIMEOUT_EN
            attempts_q <= attempts_d;
`endif
        end
    end

    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);

    lcd_tou_axil_xact #(.ADDR_W(ADDR_W)) u_xact (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .start         (xact_start),
        .is_write      (xact_is_write),
        .addr          (xact_addr),
        .wdata         (data_d),
        .done          (xact_done),
        .rdata         (xact_rdata),
        .resp          (xact_resp),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

endmodule

// File: tb/tb_lcd_tou_cmd_sequencer.sv
// Directed bench: small AXI4-Lite slave model, bus monitors and hand-computed expectations.
module tb_lcd_tou_cmd_sequencer;
    import lcd_tou_cmd_seq_pkg::*;

`ifdef LCD_TOU_CMD_SEQ_TIMEOUT_EN
    localparam int POLL_AT = 3;
`else
    localparam int POLL_AT = 5;
`endif

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_addr = '0, cmd_data = '0, cmd_mask = '0;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bready, arvalid, arready, rready;
    logic        bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    lcd_tou_cmd_sequencer #(.ADDR_W(32), .POLL_GAP(2), .POLL_MAX(4), .DLY_W(24)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_err(rsp_err), .busy(busy),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: register file, programmable AWREADY delay, BRESP error injection, POLL-status emulation on REG2.
    logic [31:0] regs [4];
    int          aw_dly = 0, aw_wait = 0;
    logic        bresp_err = 1'b0;
    logic        poll_on = 1'b0;
    int          poll_at = 0, poll_base = 0, poll_rd = 0;
    logic        got_aw = 1'b0, got_w = 1'b0;
    logic [31:0] aw_a = '0, w_dat = '0, s_a, s_d, s_rd;
    logic        aw_hs, w_hs;

    assign awready = awvalid && (aw_wait >= aw_dly) && !got_aw;
    assign wready  = !got_w;
    assign arready = !rvalid;

    always @(posedge ACLK) begin
        if (ARESET) begin
            got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0; aw_wait <= 0;
        end else begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            aw_wait <= (awvalid && !aw_hs) ? aw_wait + 1 : 0;
            if (aw_hs) begin got_aw <= 1'b1; aw_a <= awaddr; end
            if (w_hs)  begin got_w  <= 1'b1; w_dat <= wdata;  end
            s_a = aw_hs ? awaddr : aw_a;
            s_d = w_hs ? wdata : w_dat;
            if (bvalid && bready) bvalid <= 1'b0;
            if ((aw_hs || got_aw) && (w_hs || got_w)) begin
                regs[s_a[3:2]] <= s_d;
                bvalid <= 1'b1;
                bresp  <= bresp_err ? 2'b10 : 2'b00;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                s_rd = regs[araddr[3:2]];
                if (poll_on && araddr[3:2] == 2'd2) begin
                    poll_rd <= poll_rd + 1;
                    s_rd = {31'b0, (poll_at != 0) && (poll_rd + 1 - poll_base >= poll_at)};
                end
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rdata  <= s_rd;
            end
        end
    end

    // Monitor on the falling edge.
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;
    int acc_cyc = 0, rsp_cyc = 0, rsp_n = 0, ar_n = 0, aw_hi = 0, w_hi = 0;
    int unstable = 0, overlap = 0, act = 0, attr_err = 0;
    logic [31:0] r_data = '0, awa_prev = '0;
    logic [1:0]  r_resp = '0;
    logic        r_err = 1'b0, awv_prev = 1'b0;

    always @(negedge ACLK) begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (rsp_valid) begin
            rsp_n++; rsp_cyc = cyc; r_data = rsp_data; r_resp = rsp_resp; r_err = rsp_err;
        end
        if (arvalid && arready) ar_n++;
        if (awvalid) aw_hi++;
        if (wvalid) w_hi++;
        if (awvalid && awv_prev && awaddr != awa_prev) unstable++;
        awv_prev = awvalid;
        awa_prev = awaddr;
        if ((awvalid || wvalid) && arvalid) overlap++;
        if (awvalid || wvalid || arvalid) act++;
        if ((awvalid && (awprot != 3'b0 || wstrb != 4'hF)) || (arvalid && arprot != 3'b0)) attr_err++;
    end

    task automatic send(input cmd_op_e op, input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        int n = 0;
        @(posedge ACLK); #1;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
        @(negedge ACLK);
        while (!cmd_ready && n < 200) begin @(negedge ACLK); n++; end
        if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        chk("rdy_drop", {31'b0, cmd_ready}, 32'd0);
    endtask

    task automatic do_cmd(input cmd_op_e op, input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        int n0 = rsp_n;
        int n = 0;
        send(op, a, d, m);
        while (rsp_n == n0 && n < 500) begin @(negedge ACLK); n++; end
        if (rsp_n == n0) chk("rsp_timeout", 32'd0, 32'd1);
        @(negedge ACLK);
        chk("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int n0, a0;
        logic [31:0] addrs [4];
        addrs[0] = REG0; addrs[1] = REG1; addrs[2] = REG2; addrs[3] = REG3;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valids", {29'b0, awvalid, wvalid, arvalid}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_rsp_fields", {rsp_data[29:0], rsp_resp} | {31'b0, rsp_err}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            do_cmd(OP_WRITE, addrs[i], i + 1, 32'h0);
            chk("wr_lat", rsp_cyc - acc_cyc, 32'd3);
            chk("wr_resp", {29'b0, r_err, r_resp}, 32'd0);
            chk("wr_data", r_data, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            do_cmd(OP_READ, addrs[i], 32'h0, 32'h0);
            chk("rd_lat", rsp_cyc - acc_cyc, 32'd3);
            chk("rd_data", r_data, i + 1);
            chk("rd_resp", {29'b0, r_err, r_resp}, 32'd0);
        end

        // AWREADY three cycles late: AW held 4 cycles, W accepted at once, write completes at accept+6.
        aw_dly = 3;
        a0 = aw_hi; n0 = w_hi;
        do_cmd(OP_WRITE, REG1, 32'h55, 32'h0);
        chk("awdly_aw_cycles", aw_hi - a0, 32'd4);
        chk("awdly_w_cycles", w_hi - n0, 32'd1);
        chk("awdly_lat", rsp_cyc - acc_cyc, 32'd6);
        chk("awdly_stable", unstable, 32'd0);
        aw_dly = 0;
        n0 = rsp_n;
        repeat (5) @(negedge ACLK);
        chk("awdly_single_rsp", rsp_n - n0, 32'd0);
        do_cmd(OP_READ, REG1, 32'h0, 32'h0);
        chk("awdly_readback", r_data, 32'h55);

        // POLL with gap 2: one read every 4 cycles, so response at accept + 4*reads - 1.
        poll_base = poll_rd; poll_at = POLL_AT; poll_on = 1'b1;
        a0 = ar_n;
        do_cmd(OP_POLL, REG2, 32'h1, 32'h1);
        chk("poll_ar_count", ar_n - a0, POLL_AT);
        chk("poll_data", r_data, 32'h1);
        chk("poll_err", {29'b0, r_err, r_resp}, 32'd0);
        chk("poll_lat", rsp_cyc - acc_cyc, 4 * POLL_AT - 1);
        poll_on = 1'b0;

        bresp_err = 1'b1;
        do_cmd(OP_WRITE, REG3, 32'h77, 32'h0);
        chk("slverr_resp", {30'b0, r_resp}, {30'b0, RESP_SLVERR});
        chk("slverr_err", {31'b0, r_err}, 32'd1);
        bresp_err = 1'b0;

        a0 = act;
        do_cmd(OP_DELAY, 32'h0, 32'd10, 32'h0);
        chk("dly10_lat", rsp_cyc - acc_cyc, 32'd11);
        chk("dly10_rsp", {r_data[28:0], r_err, r_resp}, 32'd0);
        do_cmd(OP_DELAY, 32'h0, 32'd0, 32'h0);
        chk("dly0_lat", rsp_cyc - acc_cyc, 32'd1);
        chk("dly_no_axi", act - a0, 32'd0);

        do_cmd(OP_READ, REG3, 32'h0, 32'h0);
        chk("after_err_data", r_data, 32'h77);
        chk("after_err_resp", {29'b0, r_err, r_resp}, 32'd0);

        // Reset while AW is stalled: everything clears on the next cycle and no response follows.
        aw_dly = 50;
        n0 = rsp_n;
        send(OP_WRITE, REG0, 32'hDEAD, 32'h0);
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("midrst_valids", {29'b0, awvalid, wvalid, arvalid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        aw_dly = 0;
        repeat (5) @(negedge ACLK);
        chk("midrst_no_rsp", rsp_n - n0, 32'd0);
        do_cmd(OP_READ, REG0, 32'h0, 32'h0);
        chk("midrst_reg0_kept", r_data, 32'h1);

`ifdef LCD_TOU_CMD_SEQ_TIMEOUT_EN
        poll_base = poll_rd; poll_at = 0; poll_on = 1'b1;
        a0 = ar_n;
        do_cmd(OP_POLL, REG2, 32'h1, 32'h1);
        chk("tmo_ar_count", ar_n - a0, 32'd4);
        chk("tmo_err", {31'b0, r_err}, 32'd1);
        chk("tmo_resp_data", {r_data[29:0], r_resp}, 32'd0);
        chk("tmo_lat", rsp_cyc - acc_cyc, 32'd15);
        poll_on = 1'b0;
`endif

        chk("aw_ar_overlap", overlap, 32'd0);
        chk("prot_strb", attr_err, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_tou_cmd_sequencer.md
Name: lcd_tou_cmd_sequencer

Overview:
AXI4-Lite master that sequences register traffic into the AXI_LCD_TOU_DRI slave register file (4 x 32-bit registers, offsets 0x0/0x4/0x8/0xC).
- Accepts one command at a time from a host-side command port: WRITE, READ, POLL-until-match or DELAY.
- Runs the command as single-beat AXI4-Lite transactions and returns exactly one response per command.
- Sits between the LCD init/touch-poll firmware logic and the driver IP.

Parameters:
ADDR_W, 32, AXI address width.
POLL_GAP, 16, idle cycles between successive POLL reads (0 allowed).
POLL_MAX, 1024, max POLL read attempts; used only with TIMEOUT_EN.
DLY_W, 24, width of DELAY cycle counter (low DLY_W bits of cmd_data).

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  synchronous reset, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_op  in  2  0 WRITE, 1 READ, 2 POLL, 3 DELAY.
cmd_addr  in  ADDR_W  register byte address.
cmd_data  in  32  write data / POLL compare value / DELAY count.
cmd_mask  in  32  POLL mask.
rsp_valid  out  1  one-cycle response pulse, no backpressure.
rsp_data  out  32  read data (READ/POLL), else 0.
rsp_resp  out  2  last AXI BRESP/RRESP (0 for DELAY).
rsp_err  out  1  resp != OKAY, or POLL timeout.
busy  out  1  high in any state other than IDLE.
m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready  standard AXI4-Lite master, 32-bit data, prot = 0, wstrb = 4'hF.

Behaviour:
- Reset: all valid/ready outputs 0, rsp_data/rsp_resp/rsp_err 0, busy 0, state IDLE.
- Reset mid-transaction aborts immediately; no further beats are issued. The slave is assumed reset alongside.
- States: IDLE, WR (AW+W), WR_B, RD_AR, RD_R, GAP, DLY, RSP.
- IDLE: cmd_ready = 1. A command is registered on handshake; cmd_ready drops the next cycle.
- WRITE: AWVALID and WVALID assert the cycle after accept.
  - Each drops independently on its own handshake; values stay stable while valid.
  - WR_B is entered once both handshakes are done. BREADY = 1 in WR_B.
  - On BVALID go to RSP with rsp_resp = BRESP.
- READ: ARVALID asserts the cycle after accept. RREADY = 1 in RD_R.
  - On RVALID, capture RDATA/RRESP, then go to RSP.
- POLL: same read path. After each RVALID:
  - RRESP != OKAY: go to RSP with error.
  - (RDATA & cmd_mask) == (cmd_data & cmd_mask): go to RSP.
  - Otherwise go to GAP, count POLL_GAP cycles, return to RD_AR. POLL_GAP = 0 gives back-to-back reads with 1 idle cycle.
- DELAY: load the counter with cmd_data[DLY_W-1:0], decrement in DLY, go to RSP when it reaches 0. A count of 0 reaches RSP the cycle after accept.
- RSP: rsp_valid = 1 for exactly one cycle, next state IDLE.
  - rsp_* fields hold their value until the next response.
  - Next command is accepted no earlier than 1 cycle after rsp_valid.
- Minimum WRITE/READ latency with zero-wait slave: accept at N, rsp_valid at N+3.
- Never more than one outstanding AXI transaction; AW/W and AR are never active together.

Optional Feature:
Macro LCD_TOU_CMD_SEQ_TIMEOUT_EN.
- Defined: a POLL attempt counter (clog2(POLL_MAX+1) bits) counts completed reads. If POLL_MAX reads occur without a match, go to RSP with rsp_err = 1, rsp_data = last RDATA, rsp_resp = last RRESP.
- Undefined: POLL retries until match or error resp; the counter and POLL_MAX are unused.

Decomposition:
Package lcd_tou_cmd_seq_pkg:
- cmd_op_e enum (OP_WRITE/OP_READ/OP_POLL/OP_DELAY).
- state_e enum.
- AXI resp constants (OKAY = 0, SLVERR = 2).
- Register offset constants REG0..REG3 = 0x0..0xC.

Sub-module lcd_tou_axil_xact: single-beat AXI4-Lite write/read engine.
- Inputs: start, is_write, addr, wdata.
- Outputs: done pulse, rdata, resp.
- The top-level FSM handles POLL/DELAY/RSP sequencing around it.

Test Plan:
- WRITE 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then READ each -> rsp_data 0x1..0x4, rsp_resp 0, rsp_err 0; rsp_valid at accept+3 with zero-wait slave.
- Slave AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with stable awaddr, single response.
- POLL addr 0x8, mask 0x1, data 0x1, register bit0 set by slave after 5th read, POLL_GAP = 2 -> exactly 5 ARs, rsp_data bit0 = 1, rsp_err 0.
- DELAY 10 -> rsp_valid exactly 11 cycles after accept. DELAY 0 -> 1 cycle after accept, no AXI activity.
- Slave returns BRESP = SLVERR on WRITE -> rsp_resp = 2, rsp_err = 1. Next command is still accepted.
- ARESET asserted while WR waits for AWREADY -> next cycle all valids 0, busy 0, cmd_ready 1. With TIMEOUT_EN, POLL_MAX = 4 and no match -> 4 reads, then rsp_err = 1.
